sd_img_server: RTL and testbench
================================

Name: sd_img_server

Overview:
- Responder (server) end of the sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_* block-transfer interface used by disk controllers such as the u765.
- Serves 512-byte sector reads and writes from a disk image held in SDRAM, so an image preloaded through ioctl can be mounted without the SPI host.
- Sits between the controller's sd_* port and a spare SDRAM request port.

Parameters:
- ADDR_W, 25, width of the byte address on the memory port.
- BASE, 25'h1000000, byte address of image sector 0 in SDRAM.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sd_lba  in  32  sector number; sampled when a request is accepted.
- sd_rd  in  1  read-request level from the controller.
- sd_wr  in  1  write-request level from the controller.
- sd_ack  out  1  high for the whole transfer.
- sd_buff_addr  out  9  byte index within the sector.
- sd_buff_dout  out  8  read data to the controller.
- sd_buff_din  in  8  write data from the controller; valid 1 cycle after sd_buff_addr changes.
- sd_buff_wr  out  1  1-cycle strobe; the controller stores sd_buff_dout at sd_buff_addr.
- img_size  in  32  image size in bytes; used only with IMG_BOUNDS_EN.
- mem_addr  out  ADDR_W  SDRAM byte address.
- mem_rd  out  1  read request level.
- mem_wr  out  1  write request level.
- mem_dout  out  8  write data to SDRAM.
- mem_din  in  8  read data; valid in the mem_ready cycle.
- mem_ready  in  1  completion pulse for the pending request.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - Outputs: sd_ack=0, sd_buff_wr=0, mem_rd=0, mem_wr=0, sd_buff_addr=0, sd_buff_dout=0, mem_addr=0, mem_dout=0.
  - State returns to IDLE and the byte counter clears.
- States: IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_LATCH, WR_REQ, DONE.
- IDLE:
  - If sd_rd=1, latch sd_lba, set sd_ack=1, counter i=0, go to RD_REQ.
  - Else if sd_wr=1, do the same but go to WR_ADDR.
  - sd_rd has priority when both are high.
- Address: mem_addr = BASE + {sd_lba, 9'b0} + i, truncated to ADDR_W bits and wrapping modulo 2^ADDR_W. Upper LBA bits beyond the address width are ignored.
- Memory handshake:
  - mem_rd or mem_wr is held high from its first cycle until a cycle where mem_ready=1, then drops the next cycle.
  - mem_ready is ignored when no request is pending.
- RD_REQ: on mem_ready, capture mem_din into sd_buff_dout, set sd_buff_addr=i, go to RD_PUT.
- RD_PUT:
  - sd_buff_wr=1 for exactly this cycle.
  - If i=511, go to DONE; else i+1 and go to RD_REQ.
- WR_ADDR: drive sd_buff_addr=i, go to WR_LATCH.
- WR_LATCH: mem_dout<=sd_buff_din, go to WR_REQ.
- WR_REQ: on mem_ready, if i=511 go to DONE; else i+1 and go to WR_ADDR.
- DONE:
  - sd_ack=0.
  - Stay until sd_rd=0 and sd_wr=0, so a held level does not retrigger; then go to IDLE.
  - Minimum one cycle in DONE.
- Transfer and strobe rules:
  - Exactly 512 memory accesses per transfer, with i running 0..511 in order.
  - sd_buff_wr never asserts during writes or in IDLE/DONE.
- sd_lba changes during a transfer have no effect.
- If a request drops before completion, the transfer still runs to i=511; the controller relies on the falling edge of sd_ack.

Optional Feature:
- Macro: IMG_BOUNDS_EN.
- When defined: at acceptance, compute out = ({sd_lba, 9'b0} >= img_size), using a 41-bit compare.
  - Read with out=1: no mem_rd is issued. RD_REQ completes in one cycle with sd_buff_dout=8'h00, so 512 strobes arrive every 2nd cycle.
  - Write with out=1: the sd_buff_addr sequencing is unchanged but mem_wr is never asserted; WR_REQ completes in one cycle.
  - img_size=0 makes every sector out of range.
- When undefined: img_size is ignored and every request accesses SDRAM.

Test Plan:
- Read: sd_lba=3, mem_ready 2 cycles after each mem_rd, memory holds byte k = k[7:0] → mem_addr 25'h1000600..25'h10007FF ascending; 512 sd_buff_wr pulses with addr=k, dout=k[7:0]; sd_ack falls after the last strobe.
- Write: sd_lba=0, controller buffer returns 8'hA5^addr one cycle after the address → 512 mem_wr with mem_addr=BASE+k, mem_dout=8'hA5^k[7:0]; sd_buff_wr stays 0.
- sd_rd and sd_wr both high in IDLE → a read transfer; when sd_rd is held high after sd_ack falls, the block stays in DONE with no second transfer until both requests are low.
- reset_n pulsed low at byte 100 of a read → all outputs 0 in the same cycle; a new read after release starts at sd_buff_addr=0.
- sd_lba=32'h0001_0000 with ADDR_W=25 → mem_addr wraps to BASE+0 modulo 2^25, i.e. 25'h1000000.
- IMG_BOUNDS_EN, img_size=1024, sd_lba=2 read → no mem_rd; 512 strobes with dout=8'h00 within 1024 cycles. The same request with sd_lba=1 accesses SDRAM normally.

Source files
------------

// File: rtl/sd_img_server.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sd_img_server                                              |
// | Description : Responder end of the sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*   |
// |               block-transfer interface. Serves 512-byte sector reads and |
// |               writes from a disk image held in SDRAM at byte address     |
// |               BASE + lba*512, one byte per memory request.               |
// | Ports       : clk_sys, reset_n (async, active-low)                       |
// |               sd_lba/sd_rd/sd_wr      - request from disk controller     |
// |               sd_ack                  - high for the whole transfer      |
// |               sd_buff_addr/dout/wr    - byte index, read data, strobe    |
// |               sd_buff_din             - write data from controller       |
// |               img_size                - image size (bounds option only)  |
// |               mem_addr/rd/wr/dout     - SDRAM request port               |
// |               mem_din/mem_ready       - SDRAM read data / completion     |
// | Options     : define IMG_BOUNDS_EN to suppress SDRAM accesses for        |
// |               sectors at or beyond img_size (reads return 8'h00).        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sd_img_server #(
  parameter int                ADDR_W = 25,
  parameter logic [ADDR_W-1:0] BASE   = 25'h1000000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  input  logic [31:0]       img_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_PUT   = 3'd2,
    S_WR_ADDR  = 3'd3,
    S_WR_LATCH = 3'd4,
    S_WR_REQ   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [8:0]          i_q, i_d;
  logic [31:0]         lba_q, lba_d;
  logic                skip_q, skip_d;
  logic                ack_q, ack_d;
  logic [8:0]          buff_addr_q, buff_addr_d;
  logic [7:0]          buff_dout_q, buff_dout_d;
  logic                buff_wr_q, buff_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic [7:0]          mem_dout_q, mem_dout_d;

  logic                w_oor;
  logic                w_last;
  logic                w_load_addr;
  logic [40:0]         w_byte_addr;

`ifdef IMG_BOUNDS_EN
  // Sector start offset compared at full 41-bit width so large LBAs never alias.
  assign w_oor = ({sd_lba, 9'b0} >= {9'b0, img_size});
`else
  logic unused_img_size;
  assign unused_img_size = ^img_size;
  assign w_oor           = 1'b0;
`endif

  assign w_last = (i_q == 9'd511);

  // Only the low ADDR_W bits of the sector byte offset reach the memory port.
  logic unused_addr_hi;
  assign unused_addr_hi = ^w_byte_addr;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    lba_d       = lba_q;
    skip_d      = skip_q;
    ack_d       = ack_q;
    buff_addr_d = buff_addr_q;
    buff_dout_d = buff_dout_q;
    buff_wr_d   = 1'b0;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_dout_d  = mem_dout_q;
    w_load_addr = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sd_rd || sd_wr) begin
          lba_d       = sd_lba;
          skip_d      = w_oor;
          i_d         = 9'd0;
          ack_d       = 1'b1;
          w_load_addr = 1'b1;
          if (sd_rd) begin
            mem_rd_d = ~w_oor;
            state_d  = S_RD_REQ;
          end else begin
            // Present the byte index a full cycle ahead of the data latch.
            buff_addr_d = 9'd0;
            state_d     = S_WR_ADDR;
          end
        end
      end
      S_RD_REQ: begin
        if (skip_q || (mem_ready && mem_rd_q)) begin
          mem_rd_d    = 1'b0;
          buff_dout_d = skip_q ? 8'h00 : mem_din;
          buff_addr_d = i_q;
          buff_wr_d   = 1'b1;
          state_d     = S_RD_PUT;
        end
      end
      S_RD_PUT: begin
        if (w_last) begin
          ack_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          i_d         = i_q + 9'd1;
          w_load_addr = 1'b1;
          mem_rd_d    = ~skip_q;
          state_d     = S_RD_REQ;
        end
      end
      S_WR_ADDR: begin
        buff_addr_d = i_q;
        state_d     = S_WR_LATCH;
      end
      S_WR_LATCH: begin
        mem_dout_d = sd_buff_din;
        mem_wr_d   = ~skip_q;
        state_d    = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (skip_q || (mem_ready && mem_wr_q)) begin
          mem_wr_d = 1'b0;
          if (w_last) begin
            ack_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            i_d         = i_q + 9'd1;
            buff_addr_d = i_q + 9'd1;
            w_load_addr = 1'b1;
            state_d     = S_WR_ADDR;
          end
        end
      end
      S_DONE: begin
        // Wait for both request levels to drop so a held level cannot retrigger.
        if (!sd_rd && !sd_wr) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // lba*512 + i is a plain concatenation because i never exceeds 511.
    w_byte_addr = {lba_d, i_d};
    mem_addr_d  = w_load_addr ? (BASE + w_byte_addr[ADDR_W-1:0]) : mem_addr_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      i_q         <= 9'd0;
      lba_q       <= 32'd0;
      skip_q      <= 1'b0;
      ack_q       <= 1'b0;
      buff_addr_q <= 9'd0;
      buff_dout_q <= 8'd0;
      buff_wr_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_dout_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      lba_q       <= lba_d;
      skip_q      <= skip_d;
      ack_q       <= ack_d;
      buff_addr_q <= buff_addr_d;
      buff_dout_q <= buff_dout_d;
      buff_wr_q   <= buff_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_dout_q  <= mem_dout_d;
    end
  end

  assign sd_ack       = ack_q;
  assign sd_buff_addr = buff_addr_q;
  assign sd_buff_dout = buff_dout_q;
  assign sd_buff_wr   = buff_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign mem_dout     = mem_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_img_server.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sd_img_server                                           |
// | Description : Scoreboard bench for sd_img_server. Each transfer pushes   |
// |               its expected SDRAM accesses and buffer strobes; a monitor  |
// |               pops and compares them as the DUT presents them. Honors    |
// |               IMG_BOUNDS_EN when the design is built with it.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sd_img_server;

  localparam int          ADDR_W = 25;
  localparam logic [24:0] BASE   = 25'h1000000;
`ifdef IMG_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] sd_lba = 32'd0;
  logic        sd_rd = 1'b0;
  logic        sd_wr = 1'b0;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din = 8'd0;
  logic        sd_buff_wr;
  logic [31:0] img_size = 32'hFFFF_FFFF;
  logic [24:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = 8'd0;
  logic        mem_ready = 1'b0;

  sd_img_server #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
    .sd_buff_wr(sd_buff_wr), .img_size(img_size), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ready(mem_ready)
  );

  initial forever #5 clk_sys = ~clk_sys;

  typedef struct { bit wr; logic [24:0] addr; logic [7:0] data; } mem_ev_t;
  typedef struct { logic [8:0] addr; logic [7:0] data; } str_ev_t;
  mem_ev_t exp_mem[$];
  str_ev_t exp_str[$];

  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;
  logic [7:0] wr_seed = 8'hA5;

  // Reference: image byte k of sector lba lives at BASE + lba*512 + k mod 2^25.
  function automatic logic [24:0] ref_addr(input logic [31:0] lba, input int k);
    longint unsigned a;
    a = {32'd0, lba};
    a = a * 512 + 64'h100_0000 + longint'(k);
    return a[24:0];
  endfunction

  function automatic logic [7:0] mem_byte(input logic [24:0] a);
    return a[7:0];
  endfunction

  function automatic bit ref_out(input logic [31:0] lba);
    longint unsigned b;
    b = {32'd0, lba};
    b = b * 512;
    return BOUNDS && (b >= {32'd0, img_size});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic push_expect(input bit rd, input logic [31:0] lba, input bit out);
    logic [24:0] a;
    logic [7:0]  d;
    for (int k = 0; k < 512; k++) begin
      a = ref_addr(lba, k);
      d = wr_seed ^ 8'(k);
      if (!out) exp_mem.push_back('{wr: !rd, addr: a, data: rd ? 8'h00 : d});
      if (rd)   exp_str.push_back('{addr: 9'(k), data: out ? 8'h00 : mem_byte(a)});
    end
  endtask

  // SDRAM model: answers each pending request after 0..3 cycles and throws
  // in stray mem_ready pulses while nothing is pending.
  initial begin
    int wc;
    wc = $urandom_range(0, 3);
    forever begin
      @(negedge clk_sys);
      mem_ready = 1'b0;
      if (reset_n && (mem_rd || mem_wr)) begin
        if (wc == 0) begin
          mem_ready = 1'b1;
          mem_din   = mem_byte(mem_addr);
          wc        = $urandom_range(0, 3);
        end else begin
          wc--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_ready = 1'b1;
        mem_din   = 8'($urandom);
      end
    end
  end

  // Controller buffer: data for an index appears one cycle after the index.
  initial begin
    logic [8:0] pa;
    pa = 9'd0;
    forever begin
      @(negedge clk_sys);
      sd_buff_din = wr_seed ^ pa[7:0];
      pa = sd_buff_addr;
    end
  end

  // Monitor: compares every new memory request and buffer strobe in order.
  initial begin
    logic p_rd, p_wr, p_ack;
    mem_ev_t e;
    str_ev_t s;
    p_rd = 1'b0; p_wr = 1'b0; p_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        p_rd = 1'b0; p_wr = 1'b0; p_ack = 1'b0;
      end else begin
        if (mem_rd || mem_wr) chk("mem_rd_wr_exclusive", {mem_rd, mem_wr} == 2'b11, 0);
        if ((mem_rd && !p_rd) || (mem_wr && !p_wr)) begin
          if (exp_mem.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_mem_req: actual addr %0h rd %0b wr %0b required none",
                     mem_addr, mem_rd, mem_wr);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_dir_wr", mem_wr, e.wr);
            chk("mem_addr", mem_addr, e.addr);
            if (e.wr) chk("mem_dout", mem_dout, e.data);
          end
        end
        if (sd_buff_wr) begin
          n_strobe++;
          if (exp_str.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_strobe: actual addr %0h required none", sd_buff_addr);
          end else begin
            s = exp_str.pop_front();
            chk("buff_addr", sd_buff_addr, s.addr);
            chk("buff_dout", sd_buff_dout, s.data);
          end
        end
        if (p_ack && !sd_ack) begin
          chk("mem_drained_at_ack_fall", exp_mem.size(), 0);
          chk("strobes_drained_at_ack_fall", exp_str.size(), 0);
        end
        p_rd = mem_rd; p_wr = mem_wr; p_ack = sd_ack;
      end
    end
  end

  task automatic run_xfer(input bit rd, input bit wr, input logic [31:0] lba,
                          input int hold, input logic [7:0] seed);
    bit out;
    int t, dur, bound, rises;
    out = ref_out(lba);
    wr_seed = seed;
    push_expect(rd, lba, out);
    @(negedge clk_sys);
    sd_lba = lba; sd_rd = rd; sd_wr = wr;
    t = 0;
    while (!sd_ack && t < 8) begin @(negedge clk_sys); t++; end
    chk("ack_rise", sd_ack, 1);
    if (!sd_ack) finish_run();
    dur = 0;
    repeat ($urandom_range(0, 4)) begin @(negedge clk_sys); dur++; end
    // Dropping the request or changing lba mid-transfer must not matter.
    if (hold == 0) begin sd_rd = 1'b0; sd_wr = 1'b0; end
    sd_lba = $urandom;
    while (sd_ack && dur < 8000) begin @(negedge clk_sys); dur++; end
    chk("ack_fall", sd_ack, 0);
    if (sd_ack) finish_run();
    bound = rd ? (out ? 1030 : 512 * 6 + 8) : 512 * 7 + 8;
    chk("xfer_cycles_within_bound", dur <= bound, 1);
    if (hold > 0) begin
      rises = 0;
      repeat (hold) begin @(negedge clk_sys); if (sd_ack) rises++; end
      chk("no_retrigger_while_held", rises, 0);
      sd_rd = 1'b0; sd_wr = 1'b0;
    end
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_sd_ack"}, sd_ack, 0);
    chk({tag, "_sd_buff_wr"}, sd_buff_wr, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_sd_buff_addr"}, sd_buff_addr, 0);
    chk({tag, "_sd_buff_dout"}, sd_buff_dout, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_dout"}, mem_dout, 0);
  endtask

  task automatic reset_mid_read(input logic [31:0] lba);
    int t, target;
    wr_seed = 8'h00;
    push_expect(1'b1, lba, ref_out(lba));
    target = n_strobe + 100;
    @(negedge clk_sys);
    sd_lba = lba; sd_rd = 1'b1;
    t = 0;
    while (n_strobe < target && t < 4000) begin @(negedge clk_sys); t++; end
    chk("reached_byte_100", n_strobe >= target, 1);
    #1 reset_n = 1'b0;
    sd_rd = 1'b0;
    #1 check_outputs_zero("async_rst");
    exp_mem.delete();
    exp_str.delete();
    @(negedge clk_sys);
    @(negedge clk_sys);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #(400_000 * 10);
    n_vec++; n_err++;
    $display("FAIL watchdog: actual timeout required completion");
    finish_run();
  end

  initial begin
    logic [31:0] lba;
    bit rd;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_outputs_zero("reset");
    reset_n = 1'b1;

    img_size = 32'hFFFF_FFFF;
    run_xfer(1'b1, 1'b0, 32'd3, 0, 8'h00);           // read sector 3
    run_xfer(1'b0, 1'b1, 32'd0, 0, 8'hA5);           // write sector 0
    run_xfer(1'b1, 1'b1, 32'd7, 20, 8'h00);          // both high -> read, held
    reset_mid_read(32'd9);
    run_xfer(1'b1, 1'b0, 32'd5, 0, 8'h00);           // fresh read after reset
    run_xfer(1'b1, 1'b0, 32'h0001_0000, 0, 8'h00);   // address wraps to BASE

    img_size = 32'd1024;
    run_xfer(1'b1, 1'b0, 32'd2, 0, 8'h00);
    run_xfer(1'b1, 1'b0, 32'd1, 0, 8'h00);
    run_xfer(1'b0, 1'b1, 32'd2, 0, 8'h3C);
    img_size = 32'd0;
    run_xfer(1'b1, 1'b0, 32'd0, 0, 8'h00);

    for (int n = 0; n < 4; n++) begin
      img_size = 32'($urandom_range(0, 8) * 512 + $urandom_range(0, 1) * $urandom_range(0, 511));
      lba = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 10));
      rd  = 1'($urandom_range(0, 1));
      run_xfer(rd, !rd || ($urandom_range(0, 1) == 1), lba,
               ($urandom_range(0, 1) == 1) ? 6 : 0, 8'($urandom));
    end

    repeat (5) @(negedge clk_sys);
    chk("final_mem_queue_empty", exp_mem.size(), 0);
    chk("final_strobe_queue_empty", exp_str.size(), 0);
    finish_run();
  end

endmodule
`default_nettype wire
